// File: rtl/euler_angle_filter.sv
// Per-axis moving-average filter for IMU roll/pitch angles, with a warm-up phase and a registered output.
// Optional define EULER_FILTER_CLAMP_EN saturates samples (roll +/-2880, pitch +/-1440) before they enter the window.
module euler_angle_filter #(
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Sample_Valid,
  input  logic [15:0] i_Roll_Sample,
  input  logic [15:0] i_Pitch_Sample,
  input  logic        i_Clear,
  output logic [15:0] o_Roll_Raw,
  output logic [15:0] o_Pitch_Raw,
  output logic        o_Valid,
  output logic        o_Warm
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SW    = 16 + LOG2_DEPTH;
  localparam int unsigned CW    = LOG2_DEPTH + 1;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic                   accept;
  logic                   valid_nx;
  logic                   acc_d;
  logic                   valid_d;
  logic [CW-1:0]          count;
  logic [LOG2_DEPTH-1:0]  ptr;
  logic [15:0]            roll_buf  [DEPTH];
  logic [15:0]            pitch_buf [DEPTH];
  logic signed [SW-1:0]   roll_sum;
  logic signed [SW-1:0]   pitch_sum;
  logic signed [SW-1:0]   roll_sum_nx;
  logic signed [SW-1:0]   pitch_sum_nx;
  logic signed [SW-1:0]   roll_shift;
  logic signed [SW-1:0]   pitch_shift;
  logic [15:0]            roll_in;
  logic [15:0]            pitch_in;

  // Clear takes priority: a sample strobed alongside it is dropped.
  assign accept = i_Sample_Valid & ~i_Clear;

`ifdef EULER_FILTER_CLAMP_EN
  function automatic logic [15:0] saturate(input logic [15:0] x, input logic [15:0] lim);
    logic signed [15:0] xs;
    logic signed [15:0] ls;
    xs = $signed(x);
    ls = $signed(lim);
    if (xs > ls) begin
      return lim;
    end else if (xs < -ls) begin
      return 16'(-ls);
    end else begin
      return x;
    end
  endfunction

  assign roll_in  = saturate(i_Roll_Sample,  16'd2880);
  assign pitch_in = saturate(i_Pitch_Sample, 16'd1440);
`else
  assign roll_in  = i_Roll_Sample;
  assign pitch_in = i_Pitch_Sample;
`endif

  // Running sums: add the incoming sample, retire the entry it overwrites.
  always_comb begin
    roll_sum_nx  = roll_sum
                 + {{LOG2_DEPTH{roll_in[15]}}, roll_in}
                 - {{LOG2_DEPTH{roll_buf[ptr][15]}}, roll_buf[ptr]};
    pitch_sum_nx = pitch_sum
                 + {{LOG2_DEPTH{pitch_in[15]}}, pitch_in}
                 - {{LOG2_DEPTH{pitch_buf[ptr][15]}}, pitch_buf[ptr]};
    roll_shift   = roll_sum  >>> LOG2_DEPTH;
    pitch_shift  = pitch_sum >>> LOG2_DEPTH;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= WARMUP;
    end else begin
      state <= state_nx;
    end
  end

  // Warm-up suppresses o_Valid until the DEPTH-th accept, which itself is reported.
  always_comb begin
    state_nx = state;
    valid_nx = 1'b0;
    case (state)
      WARMUP: begin
        if (accept && (count == CW'(DEPTH - 1))) begin
          state_nx = RUN;
          valid_nx = 1'b1;
        end
      end
      RUN: begin
        valid_nx = accept;
      end
      default: begin
        state_nx = WARMUP;
      end
    endcase
    if (i_Clear) begin
      state_nx = WARMUP;
    end
  end

  assign o_Warm = (state == RUN);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        roll_buf[i]  <= '0;
        pitch_buf[i] <= '0;
      end
      roll_sum    <= '0;
      pitch_sum   <= '0;
      ptr         <= '0;
      count       <= '0;
      acc_d       <= 1'b0;
      valid_d     <= 1'b0;
      o_Valid     <= 1'b0;
      o_Roll_Raw  <= '0;
      o_Pitch_Raw <= '0;
    end else if (i_Clear) begin
      // Flush window and pipeline; the output registers keep their last value.
      for (int i = 0; i < int'(DEPTH); i++) begin
        roll_buf[i]  <= '0;
        pitch_buf[i] <= '0;
      end
      roll_sum  <= '0;
      pitch_sum <= '0;
      ptr       <= '0;
      count     <= '0;
      acc_d     <= 1'b0;
      valid_d   <= 1'b0;
      o_Valid   <= 1'b0;
    end else begin
      acc_d   <= accept;
      valid_d <= valid_nx;
      o_Valid <= valid_d;
      if (accept) begin
        roll_sum       <= roll_sum_nx;
        pitch_sum      <= pitch_sum_nx;
        roll_buf[ptr]  <= roll_in;
        pitch_buf[ptr] <= pitch_in;
        ptr            <= ptr + LOG2_DEPTH'(1);
        if (state == WARMUP) begin
          count <= count + CW'(1);
        end
      end
      // Outputs track every accept, including during warm-up, one cycle after the sum.
      if (acc_d) begin
        o_Roll_Raw  <= roll_shift[15:0];
        o_Pitch_Raw <= pitch_shift[15:0];
      end
    end
  end

endmodule

// File: tb/tb_euler_angle_filter.sv
// Scoreboard bench for euler_angle_filter: a window-average reference model feeds an expectation queue
// that a negedge monitor drains whenever o_Valid is seen.
module tb_euler_angle_filter;

  localparam int L = 3;
  localparam int D = 1 << L;
`ifdef EULER_FILTER_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic        clear;
  logic [15:0] roll;
  logic [15:0] pitch;
  logic [15:0] roll_out;
  logic [15:0] pitch_out;
  logic        out_valid;
  logic        warm;

  always #5 clk = ~clk;

  euler_angle_filter #(.LOG2_DEPTH(L)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Sample_Valid (sample_valid),
    .i_Roll_Sample  (roll),
    .i_Pitch_Sample (pitch),
    .i_Clear        (clear),
    .o_Roll_Raw     (roll_out),
    .o_Pitch_Raw    (pitch_out),
    .o_Valid        (out_valid),
    .o_Warm         (warm)
  );

  typedef struct {
    int r;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   win_r[$];
  int   win_p[$];
  int   acc_cnt;
  bit   m_warm;
  bit   mon_en;
  int   last_r;
  int   last_p;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int clampv(int x, int lim);
    if (CLAMP && x > lim) return lim;
    if (CLAMP && x < -lim) return -lim;
    return x;
  endfunction

  // Mean of the window rounded toward minus infinity.
  function automatic int floor_avg(int s);
    int q;
    q = s / D;
    if (s < 0 && q * D != s) q = q - 1;
    return q;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    win_r.delete();
    win_p.delete();
    for (int i = 0; i < D; i++) begin
      win_r.push_back(0);
      win_p.push_back(0);
    end
    acc_cnt = 0;
    m_warm  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [15:0] r, input logic [15:0] p, input logic clr);
    int   sr;
    int   sp;
    exp_t e;
    if (clr) begin
      model_reset();
    end else if (v) begin
      win_r.push_back(clampv(int'($signed(r)), 2880));
      win_p.push_back(clampv(int'($signed(p)), 1440));
      void'(win_r.pop_front());
      void'(win_p.pop_front());
      acc_cnt++;
      if (acc_cnt >= D) begin
        m_warm = 1'b1;
        sr = 0;
        sp = 0;
        foreach (win_r[i]) sr += win_r[i];
        foreach (win_p[i]) sp += win_p[i];
        e.r = floor_avg(sr);
        e.p = floor_avg(sp);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive one cycle of stimulus; the model advances on the edge that samples it.
  task automatic step(input logic v, input logic [15:0] r, input logic [15:0] p, input logic clr);
    sample_valid = v;
    roll         = r;
    pitch        = p;
    clear        = clr;
    @(posedge clk);
    model_step(v, r, p, clr);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("warm", int'(warm), int'(m_warm));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got o_Valid=1, expected no pending result (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("roll", int'($signed(roll_out)), e.r);
          check("pitch", int'($signed(pitch_out)), e.p);
          last_r = e.r;
          last_p = e.p;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst          = 1'b0;
    sample_valid = 1'b0;
    clear        = 1'b0;
    roll         = '0;
    pitch        = '0;
    mon_en       = 1'b0;
    last_r       = 0;
    last_p       = 0;
    model_reset();

    // Asynchronous reset, asserted between edges.
    #3 rst = 1'b1;
    #1;
    check("rst_roll", int'(roll_out), 0);
    check("rst_pitch", int'(pitch_out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_warm", int'(warm), 0);
    #20;
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    idle(5);

    // Warm-up with a constant pair.
    for (int i = 0; i < 8; i++) step(1'b1, 16'd160, 16'hFEC0, 1'b0);
    idle(3);
    check("warm_roll", int'($signed(roll_out)), 160);
    check("warm_pitch", int'($signed(pitch_out)), -320);

    // Alternating -1/0 exercises truncation toward minus infinity.
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 16'hFFFF : 16'h0000, 16'h0000, 1'b0);
    idle(3);
    check("trunc_roll", int'($signed(roll_out)), -1);

    // Window slide.
    for (int i = 0; i < 8; i++) step(1'b1, 16'd0, 16'd0, 1'b0);
    idle(3);
    step(1'b1, 16'd800, 16'd0, 1'b0);
    idle(3);
    check("slide_first", int'($signed(roll_out)), 100);
    for (int i = 0; i < 7; i++) step(1'b1, 16'd800, 16'd0, 1'b0);
    idle(3);
    check("slide_full", int'($signed(roll_out)), 800);

    // Clear coincident with a strobe.
    step(1'b1, 16'd999, 16'd999, 1'b1);
    idle(3);
    check("clear_hold_roll", int'($signed(roll_out)), 800);
    check("clear_hold_pitch", int'($signed(pitch_out)), 0);
    check("clear_warm", int'(warm), 0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    idle(3);

    // Extreme values: saturated when the clamp is built in, averaged as-is otherwise.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h7FFF, 16'h8000, 1'b0);
    idle(3);
    check("extreme_roll", int'($signed(roll_out)), CLAMP ? 2880 : 32767);
    check("extreme_pitch", int'($signed(pitch_out)), CLAMP ? -1440 : -32768);

    // Random traffic with gaps and occasional clears.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 16'($urandom), 16'($urandom),
           ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    check("drain_pending", exp_q.size(), 0);

    // Reset mid-stream kills in-flight results.
    for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_roll", int'(roll_out), 0);
    check("mid_rst_pitch", int'(pitch_out), 0);
    check("mid_rst_warm", int'(warm), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
